// File: rtl/stream_64to32_serializer_if.sv
// stream_64to32_serializer_if: 64-bit slave side and 32-bit master side of the width down-converter
interface stream_64to32_serializer_if #(
    parameter int CNT_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [63:0]      s_data;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic             m_last;
    logic [CNT_W-1:0] word_cnt;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last, word_cnt
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last, word_cnt
    );
endinterface

// File: rtl/stream_64to32_serializer.sv
// stream_64to32_serializer: splits each accepted 64-bit word into two 32-bit beats, counting completed words
module stream_64to32_serializer #(
    parameter int LOW_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic rst,
    stream_64to32_serializer_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, FIRST, SECOND} state_t;

    state_t      state_q;
    logic [63:0] hold_q;

    function automatic logic [31:0] half(input logic [63:0] w, input logic second);
        return (second == (LOW_FIRST != 0)) ? w[63:32] : w[31:0];
    endfunction

    // A new word can enter when idle, or when the final beat leaves this cycle
    assign bus.s_ready = ~rst & (state_q == EMPTY | (state_q == SECOND & bus.m_ready));

    // Beat sequencing; outputs are registered alongside the state so m_data never sees s_data combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            hold_q       <= '0;
            bus.m_valid  <= 1'b0;
            bus.m_data   <= '0;
            bus.m_last   <= 1'b0;
            bus.word_cnt <= '0;
        end else begin
            case (state_q)
                EMPTY: if (bus.s_valid) begin
                    hold_q      <= bus.s_data;
                    state_q     <= FIRST;
                    bus.m_valid <= 1'b1;
                    bus.m_last  <= 1'b0;
                    bus.m_data  <= half(bus.s_data, 1'b0);
                end
                FIRST: if (bus.m_ready) begin
                    state_q    <= SECOND;
                    bus.m_last <= 1'b1;
                    bus.m_data <= half(hold_q, 1'b1);
                end
                SECOND: if (bus.m_ready) begin
                    bus.word_cnt <= bus.word_cnt + 1'b1;
                    bus.m_last   <= 1'b0;
                    if (bus.s_valid) begin
                        hold_q     <= bus.s_data;
                        state_q    <= FIRST;
                        bus.m_data <= half(bus.s_data, 1'b0);
                    end else begin
                        state_q     <= EMPTY;
                        bus.m_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    bus.m_valid <= 1'b0;
                    bus.m_last  <= 1'b0;
                end
            endcase
        end
    end
endmodule
